// File: rtl/byte_data_memory_pkg.sv
// data_memory_pkg: shared size encodings, FSM states and counter width for byte_data_memory
package data_memory_pkg;
  localparam int LAT_W = 4;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/byte_data_memory_if.sv
// byte_data_memory_if: request/acknowledge bus between the MEM stage and the data memory
interface byte_data_memory_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        ack_o;
  logic [31:0] data_o;
  logic        err_o;
  modport master(output req_i, we_i, size_i, unsigned_i, addr_i, data_i, input ready_o, ack_o, data_o, err_o);
  modport slave(input req_i, we_i, size_i, unsigned_i, addr_i, data_i, output ready_o, ack_o, data_o, err_o);
endinterface

// File: rtl/byte_data_memory_lane_align.sv
// byte_lane_align: little-endian lane steering for stores and extraction/extension for loads
module byte_lane_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  strb,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);
  logic [4:0]  sh;
  logic [31:0] rs;
  assign sh    = {addr, 3'b000};
  assign rs    = rword >> sh;
  assign wlane = wdata << sh;
  assign strb  = size == SIZE_B ? 4'b0001 << addr :
                 size == SIZE_H ? 4'b0011 << addr :
                 size == SIZE_W ? 4'b1111 : 4'b0000;
  assign rdata = size == SIZE_B ? {{24{~uns & rs[7]}}, rs[7:0]} :
                 size == SIZE_H ? {{16{~uns & rs[15]}}, rs[15:0]} : rs;
endmodule

// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressable little-endian data memory with req/ack handshake and fixed latency
module byte_data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_BYTES = 32,
  parameter int LATENCY     = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  byte_data_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  state_t             state, state_n;
  logic [LAT_W-1:0]   cnt;
  logic               we_r, uns_r;
  logic [1:0]         size_r;
  logic [31:0]        addr_r, wdata_r;
  logic [7:0]         mem [0:DEPTH_BYTES-1];
  logic [31:0]        rword, wlane, rdata;
  logic [3:0]         strb;
  logic               accept, done, err;
  assign bus.ready_o = state != BUSY;
  assign accept      = bus.req_i && bus.ready_o;
  assign done        = state == BUSY && cnt == '0;
  assign err         = size_r == 2'b11 || (size_r == SIZE_H && addr_r[0]) ||
                       (size_r == SIZE_W && |addr_r[1:0]) || addr_r >= 32'(DEPTH_BYTES);
  for (genvar i = 0; i < 4; i++) begin : g_rd
    assign rword[8*i +: 8] = mem[{addr_r[AW-1:2], 2'(i)}];
  end
  byte_lane_align u_align (
    .size  (size_r),
    .addr  (addr_r[1:0]),
    .uns   (uns_r),
    .wdata (wdata_r),
    .rword (rword),
    .strb  (strb),
    .wlane (wlane),
    .rdata (rdata)
  );
  always_comb begin
    state_n = accept ? BUSY : state == BUSY ? (cnt == '0 ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      we_r       <= 1'b0;
      uns_r      <= 1'b0;
      size_r     <= SIZE_B;
      addr_r     <= '0;
      wdata_r    <= '0;
      bus.ack_o  <= 1'b0;
      bus.data_o <= '0;
      bus.err_o  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= accept ? LAT_W'(LATENCY - 1) : state == BUSY ? cnt - 1'b1 : cnt;
      bus.ack_o <= done;
      bus.err_o <= done && err;
      if (done) bus.data_o <= (err || we_r) ? '0 : rdata;
      if (accept) begin
        we_r    <= bus.we_i;
        uns_r   <= bus.unsigned_i;
        size_r  <= bus.size_i;
        addr_r  <= bus.addr_i;
        wdata_r <= bus.data_i;
      end
    end
  end
  // Memory has no reset; an aborting reset forces IDLE so done can never fire under it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (rst_i && done && we_r && !err && strb[i]) mem[{addr_r[AW-1:2], 2'(i)}] <= wlane[8*i +: 8];
  end
endmodule

// File: tb/tb_byte_data_memory.sv
// tb_byte_data_memory: directed and random checks of byte_data_memory against a byte-array model
module tb_byte_data_memory;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m [2][DEPTH];
  always #5 clk = ~clk;
  byte_data_memory_if b1();
  byte_data_memory_if b3();
  byte_data_memory #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u1 (.clk_i(clk), .rst_i(rst_n), .bus(b1));
  byte_data_memory #(.DEPTH_BYTES(DEPTH), .LATENCY(3)) u3 (.clk_i(clk), .rst_i(rst_n), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input int u, input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic re);
    int n;
    n  = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
    re = (n == 0) ? 1'b1 : (a >= DEPTH || (a % n) != 0);
    rd = '0;
    if (!re) begin
      if (we) for (int i = 0; i < n; i++) m[u][a+i] = d[8*i +: 8];
      else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = m[u][a+i];
        if (!uns && rd[8*n-1]) rd |= 32'hFFFF_FFFF << (8*n);
      end
    end
  endfunction

  task automatic acc(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] ed;
    logic ee;
    int c;
    model(0, we, sz, uns, a, d, ed, ee);
    b1.req_i = 1'b1; b1.we_i = we; b1.size_i = sz; b1.unsigned_i = uns; b1.addr_i = a; b1.data_i = d;
    @(posedge clk);
    #1 b1.req_i = 1'b0; b1.data_i = $urandom; b1.addr_i = $urandom;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 1) chk({tag, " busy_ready"}, 32'(b1.ready_o), 32'd0);
    end while (!b1.ack_o && c < 20);
    chk({tag, " ack_cycles"}, c, 2);
    chk({tag, " data"}, b1.data_o, ed);
    chk({tag, " err"}, 32'(b1.err_o), 32'(ee));
    @(negedge clk);
    chk({tag, " ack_width"}, 32'(b1.ack_o), 32'd0);
  endtask

  initial begin
    logic [31:0] ed, d;
    logic ee;
    logic [1:0] sz;
    {b1.req_i, b1.we_i, b1.size_i, b1.unsigned_i, b1.addr_i, b1.data_i} = '0;
    {b3.req_i, b3.we_i, b3.size_i, b3.unsigned_i, b3.addr_i, b3.data_i} = '0;
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(b1.ready_o), 32'd1);
    chk("rst ack", 32'(b1.ack_o), 32'd0);
    chk("rst data", b1.data_o, 32'd0);
    chk("rst err", 32'(b1.err_o), 32'd0);
    chk("rst3 ready", 32'(b3.ready_o), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < DEPTH; a += 4) acc(1'b1, 2'd2, 1'b0, a, $urandom, "init");
    acc(1'b1, 2'd2, 1'b0, 32'h4, 32'h8C7F_0123, "sw4");
    acc(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw4");
    chk("lw4 literal", b1.data_o, 32'h8C7F_0123);
    acc(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, "lb7");
    chk("lb7 literal", b1.data_o, 32'hFFFF_FF8C);
    acc(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, "lbu7");
    chk("lbu7 literal", b1.data_o, 32'h0000_008C);
    acc(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, "lh6");
    chk("lh6 literal", b1.data_o, 32'hFFFF_8C7F);
    acc(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, "lhu6");
    chk("lhu6 literal", b1.data_o, 32'h0000_8C7F);
    acc(1'b1, 2'd0, 1'b0, 32'h5, 32'h1234_56AA, "sb5");
    acc(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw4b");
    chk("lw4b literal", b1.data_o, 32'h8C7F_AA23);
    acc(1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF_FFFF, "sh3");
    acc(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, "lw2");
    acc(1'b1, 2'd2, 1'b0, DEPTH, 32'hFFFF_FFFF, "swdepth");
    acc(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, "sz11");
    acc(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "lw0");
    acc(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw4c");
    chk("lw4c literal", b1.data_o, 32'h8C7F_AA23);
    for (int k = 0; k < 60; k++)
      acc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom_range(0, DEPTH + 3), $urandom, "rand");
    b1.req_i = 1'b1; b1.we_i = 1'b1; b1.size_i = 2'd2; b1.addr_i = 32'h8; b1.data_i = 32'h1234_5678;
    @(posedge clk);
    #1 b1.req_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("abort ready", 32'(b1.ready_o), 32'd1);
    chk("abort ack", 32'(b1.ack_o), 32'd0);
    chk("abort data", b1.data_o, 32'd0);
    chk("abort err", 32'(b1.err_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "abort lw8");
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      sz = k < 4 ? 2'd2 : 2'($urandom_range(0, 2));
      b3.req_i = 1'b1; b3.we_i = k < 4; b3.size_i = sz; b3.unsigned_i = 1'($urandom_range(0, 1));
      b3.addr_i = k < 4 ? 32'(4 * k) : 32'(4 * (k - 4) + (sz == 2'd0 ? 3 : sz == 2'd1 ? 2 : 0));
      b3.data_i = d;
      model(1, b3.we_i, sz, b3.unsigned_i, b3.addr_i, d, ed, ee);
      @(posedge clk);
      #1 if (k == 7) b3.req_i = 1'b0;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk("b2b ready_low", 32'(b3.ready_o), 32'd0);
        chk("b2b ack_low", 32'(b3.ack_o), 32'd0);
      end
      @(negedge clk);
      chk("b2b ack", 32'(b3.ack_o), 32'd1);
      chk("b2b ready_resp", 32'(b3.ready_o), 32'd1);
      chk("b2b data", b3.data_o, ed);
      chk("b2b err", 32'(b3.err_o), 32'(ee));
    end
    @(negedge clk);
    chk("b2b idle ack", 32'(b3.ack_o), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
